// File: rtl/instruction_decode_controller.sv
// instruction_decode_controller
// Fetches one instruction at a time from a synchronous instruction memory,
// decodes it, and hands ADD/MULT work to the matching execution controller.
// Once that controller finishes, the next pc it returns is loaded and the
// instruction is counted as retired.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to trap unknown opcodes
// into HALT with illegal=1. When it is undefined, unknown opcodes act as NOP.
module instruction_decode_controller #(
   parameter int WORD_SIZE              = 32,
   parameter int NUMBER_OF_PC_REGISTERS = 256,
   parameter int NUMBER_OF_REGISTERS    = 32,
   localparam int PC_WIDTH              = $clog2(NUMBER_OF_PC_REGISTERS),
   localparam int ADDR_WIDTH            = $clog2(NUMBER_OF_REGISTERS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic [WORD_SIZE-1:0]  imem_data,
   output logic                  add_start,
   output logic                  mult_start,
   output logic [PC_WIDTH-1:0]   exe_pc,
   output logic [1:0]            operation_type,
   output logic [ADDR_WIDTH-1:0] source_1_address,
   output logic [ADDR_WIDTH-1:0] source_2_address,
   output logic [ADDR_WIDTH-1:0] destination_address,
   output logic [WORD_SIZE-1:0]  source_immediate_value,
   input  logic                  add_busy,
   input  logic                  add_done,
   input  logic                  mult_busy,
   input  logic                  mult_done,
   input  logic [PC_WIDTH-1:0]   add_next_pc,
   input  logic [PC_WIDTH-1:0]   mult_next_pc,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  halted,
   output logic                  illegal,
   output logic [15:0]           instr_count
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_FETCH_IMM = 4'd3;
   localparam logic [3:0] S_LATCH_IMM = 4'd4;
   localparam logic [3:0] S_ISSUE     = 4'd5;
   localparam logic [3:0] S_WAIT_BUSY = 4'd6;
   localparam logic [3:0] S_WAIT_DONE = 4'd7;
   localparam logic [3:0] S_HALT      = 4'd8;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_MULT = 4'h2;
   localparam logic [3:0] OP_HALT = 4'hF;

   logic [3:0]          state;
   logic                is_mult;
   logic [PC_WIDTH-1:0] pc_plus_one;
   logic [15:0]         count_next;
   logic [3:0]          opcode;
   logic                is_imm;
   logic                sel_busy;
   logic                sel_done;
   logic [PC_WIDTH-1:0] sel_next_pc;
   logic                unused_bits;

   assign pc_plus_one = pc + PC_WIDTH'(1);
   assign count_next  = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
   assign opcode      = imem_data[31:28];
   assign is_imm      = (imem_data[27:26] == 2'd1);
   assign sel_busy    = is_mult ? mult_busy : add_busy;
   assign sel_done    = is_mult ? mult_done : add_done;
   assign sel_next_pc = is_mult ? mult_next_pc : add_next_pc;
   assign unused_bits = ^imem_data;

   // The immediate word sits right after the instruction, so only FETCH_IMM looks ahead.
   assign imem_addr = (state == S_FETCH_IMM) ? pc_plus_one : pc;

`ifndef DECODE_ILLEGAL_TRAP_EN
   assign illegal = 1'b0;
`endif

   // Main sequencer: fetch, decode, issue to a controller, then retire on its completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= S_IDLE;
         pc                     <= '0;
         instr_count            <= '0;
         halted                 <= 1'b0;
         add_start              <= 1'b0;
         mult_start             <= 1'b0;
         is_mult                <= 1'b0;
         exe_pc                 <= '0;
         operation_type         <= '0;
         source_1_address       <= '0;
         source_2_address       <= '0;
         destination_address    <= '0;
         source_immediate_value <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal                <= 1'b0;
`endif
      end else begin
         add_start  <= 1'b0;
         mult_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) state <= S_FETCH;
            end
            S_FETCH: begin
               state <= S_DECODE;
            end
            S_DECODE: begin
               case (opcode)
                  OP_NOP: begin
                     pc          <= pc_plus_one;
                     instr_count <= count_next;
                     state       <= S_IDLE;
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  OP_ADD, OP_MULT: begin
                     is_mult             <= (opcode == OP_MULT);
                     operation_type      <= {1'b0, is_imm};
                     destination_address <= imem_data[25:21];
                     source_1_address    <= imem_data[20:16];
                     source_2_address    <= imem_data[15:11];
                     if (is_imm) begin
                        exe_pc <= pc_plus_one;
                        state  <= S_FETCH_IMM;
                     end else begin
                        exe_pc     <= pc;
                        add_start  <= (opcode == OP_ADD);
                        mult_start <= (opcode == OP_MULT);
                        state      <= S_ISSUE;
                     end
                  end
                  default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                     illegal <= 1'b1;
                     halted  <= 1'b1;
                     state   <= S_HALT;
`else
                     pc          <= pc_plus_one;
                     instr_count <= count_next;
                     state       <= S_IDLE;
`endif
                  end
               endcase
            end
            S_FETCH_IMM: begin
               state <= S_LATCH_IMM;
            end
            S_LATCH_IMM: begin
               source_immediate_value <= imem_data;
               add_start              <= !is_mult;
               mult_start             <= is_mult;
               state                  <= S_ISSUE;
            end
            S_ISSUE: begin
               state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (sel_busy) state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (sel_done && !sel_busy) begin
                  pc          <= sel_next_pc;
                  instr_count <= count_next;
                  state       <= S_IDLE;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_decode_controller.sv
// tb_instruction_decode_controller
// Drives small programs through a synchronous instruction memory model and a
// shared add/mult controller model. Expected start pulses are queued as the
// program is loaded and compared when the decoder issues them.
module tb_instruction_decode_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        add_start;
   logic        mult_start;
   logic [7:0]  exe_pc;
   logic [1:0]  operation_type;
   logic [4:0]  source_1_address;
   logic [4:0]  source_2_address;
   logic [4:0]  destination_address;
   logic [31:0] source_immediate_value;
   logic        add_busy;
   logic        add_done;
   logic        mult_busy;
   logic        mult_done;
   logic [7:0]  add_next_pc;
   logic [7:0]  mult_next_pc;
   logic [7:0]  pc;
   logic        halted;
   logic        illegal;
   logic [15:0] instr_count;

   typedef struct {
      logic        unit;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [1:0]  typ;
      logic [7:0]  epc;
      logic [31:0] imm;
   } start_t;

   start_t      exp_q[$];
   start_t      seen;
   logic [31:0] cur_imm;
   logic [31:0] mem [256];
   logic [7:0]  ret_tab [256];

   int check_count = 0;
   int pass_count  = 0;

   logic       m_sel       = 1'b0;
   logic       m_busy      = 1'b0;
   logic       m_done      = 1'b0;
   logic [7:0] m_ret       = 8'd0;
   int         m_phase     = 0;
   int         m_cnt       = 0;
   int         pre_cycles  = 1;
   int         busy_cycles = 2;
   logic       hold_done   = 1'b0;
   logic       model_clear = 1'b0;

   instruction_decode_controller dut (
      .clk                    (clk),
      .rst                    (rst),
      .run                    (run),
      .imem_addr              (imem_addr),
      .imem_data              (imem_data),
      .add_start              (add_start),
      .mult_start             (mult_start),
      .exe_pc                 (exe_pc),
      .operation_type         (operation_type),
      .source_1_address       (source_1_address),
      .source_2_address       (source_2_address),
      .destination_address    (destination_address),
      .source_immediate_value (source_immediate_value),
      .add_busy               (add_busy),
      .add_done               (add_done),
      .mult_busy              (mult_busy),
      .mult_done              (mult_done),
      .add_next_pc            (add_next_pc),
      .mult_next_pc           (mult_next_pc),
      .pc                     (pc),
      .halted                 (halted),
      .illegal                (illegal),
      .instr_count            (instr_count)
   );

   always #5 clk = ~clk;

   // Instruction memory returns the addressed word one cycle after the address.
   always @(posedge clk) begin
      imem_data <= mem[imem_addr];
   end

   // Controller model: optional pre-busy delay, busy window, then a done pulse (or held done).
   always @(posedge clk) begin
      if (model_clear) begin
         m_phase <= 0;
         m_cnt   <= 0;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_sel   <= 1'b0;
      end else if (add_start || mult_start) begin
         m_sel   <= mult_start;
         m_ret   <= ret_tab[exe_pc];
         m_phase <= 1;
         m_cnt   <= pre_cycles;
         if (!hold_done) m_done <= 1'b0;
      end else begin
         case (m_phase)
            1: begin
               if (m_cnt == 0) begin
                  m_phase <= 2;
                  m_busy  <= 1'b1;
                  m_done  <= 1'b0;
                  m_cnt   <= busy_cycles;
               end else m_cnt <= m_cnt - 1;
            end
            2: begin
               if (m_cnt == 0) begin
                  m_phase <= 0;
                  m_busy  <= 1'b0;
                  m_done  <= 1'b1;
               end else m_cnt <= m_cnt - 1;
            end
            default: begin
               if (!hold_done) m_done <= 1'b0;
            end
         endcase
      end
   end

   assign add_busy     = m_busy && !m_sel;
   assign add_done     = m_done && !m_sel;
   assign mult_busy    = m_busy && m_sel;
   assign mult_done    = m_done && m_sel;
   assign add_next_pc  = m_ret;
   assign mult_next_pc = m_ret;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      else
         pass_count++;
   endtask

   // Every start pulse is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (add_start || mult_start) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_start", 32'(add_start | mult_start), 32'd0);
         end else begin
            seen = exp_q.pop_front();
            checkOutput("start_unit", 32'(mult_start), 32'(seen.unit));
            checkOutput("single_start", 32'(add_start & mult_start), 32'd0);
            checkOutput("rd", 32'(destination_address), 32'(seen.rd));
            checkOutput("rs1", 32'(source_1_address), 32'(seen.rs1));
            checkOutput("rs2", 32'(source_2_address), 32'(seen.rs2));
            checkOutput("op_type", 32'(operation_type), 32'(seen.typ));
            checkOutput("exe_pc", 32'(exe_pc), 32'(seen.epc));
            checkOutput("imm", source_immediate_value, seen.imm);
         end
      end
   end

   // Load one instruction (plus immediate word) and queue the start it should produce.
   task automatic applyStimulus(input logic [7:0] addr, input logic [3:0] op, input logic [1:0] typ,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [7:0] ret);
      start_t s;
      mem[addr] = {op, typ, rd, rs1, rs2, 11'h2A5};
      if (op == 4'h1 || op == 4'h2) begin
         s.unit = (op == 4'h2);
         s.rd   = rd;
         s.rs1  = rs1;
         s.rs2  = rs2;
         s.typ  = (typ == 2'd1) ? 2'd1 : 2'd0;
         if (typ == 2'd1) begin
            mem[addr + 8'd1] = imm;
            cur_imm = imm;
            s.epc = addr + 8'd1;
         end else begin
            s.epc = addr;
         end
         s.imm = cur_imm;
         ret_tab[s.epc] = ret;
         exp_q.push_back(s);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hF000_0000;
         ret_tab[i] = 8'd0;
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_pc", 32'(pc), 32'd0);
      checkOutput("rst_count", 32'(instr_count), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_add_start", 32'(add_start), 32'd0);
      checkOutput("rst_mult_start", 32'(mult_start), 32'd0);
      checkOutput("rst_exe_pc", 32'(exe_pc), 32'd0);
      checkOutput("rst_op_type", 32'(operation_type), 32'd0);
      checkOutput("rst_rd", 32'(destination_address), 32'd0);
      checkOutput("rst_rs1", 32'(source_1_address), 32'd0);
      checkOutput("rst_rs2", 32'(source_2_address), 32'd0);
      checkOutput("rst_imm", source_immediate_value, 32'd0);
   endtask

   task automatic doReset(input logic clear_model);
      @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      model_clear = clear_model;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear = 1'b0;
      cur_imm = 32'd0;
      checkResetState();
   endtask

   task automatic waitHalted(input int budget, input string tag);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_halted"}, 32'(halted), 32'd1);
   endtask

   task automatic waitStart(input int budget, input string tag);
      int n = 0;
      while (!(add_start || mult_start) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_start_seen"}, 32'(add_start | mult_start), 32'd1);
   endtask

   task automatic endTest(input string tag);
      checkOutput({tag, "_pending_starts"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b0;
      model_clear = 1'b1;
      cur_imm = 32'd0;
      clearMem();

      // MULT R then HALT; halt must persist while run stays high
      doReset(1'b1);
      clearMem();
      applyStimulus(8'd0, 4'h2, 2'd0, 5'd3, 5'd1, 5'd2, 32'd0, 8'd1);
      applyStimulus(8'd1, 4'hF, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      run = 1'b1;
      waitHalted(200, "mult_r");
      checkOutput("mult_r_pc", 32'(pc), 32'd1);
      checkOutput("mult_r_count", 32'(instr_count), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("halt_hold", 32'(halted), 32'd1);
      checkOutput("halt_hold_pc", 32'(pc), 32'd1);
      endTest("mult_r");

      // NOPs, then ADD I at 4, MULT I at 6, ADD R at 8 holding the last immediate
      doReset(1'b1);
      clearMem();
      for (int i = 0; i < 4; i++)
         applyStimulus(8'(i), 4'h0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      applyStimulus(8'd4, 4'h1, 2'd1, 5'd7, 5'd4, 5'd9, 32'h4040_0000, 8'd6);
      applyStimulus(8'd6, 4'h2, 2'd1, 5'd8, 5'd10, 5'd11, 32'hDEAD_BEEF, 8'd8);
      applyStimulus(8'd8, 4'h1, 2'd0, 5'd12, 5'd13, 5'd14, 32'd0, 8'd9);
      applyStimulus(8'd9, 4'hF, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      run = 1'b1;
      waitHalted(400, "imm");
      checkOutput("imm_pc", 32'(pc), 32'd9);
      checkOutput("imm_count", 32'(instr_count), 32'd7);
      checkOutput("imm_held", source_immediate_value, 32'hDEAD_BEEF);
      endTest("imm");

      // Stale done held from the previous ADD must not retire the next one early
      doReset(1'b1);
      clearMem();
      pre_cycles  = 3;
      busy_cycles = 2;
      hold_done   = 1'b1;
      applyStimulus(8'd0, 4'h1, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0, 8'd1);
      applyStimulus(8'd1, 4'h1, 2'd0, 5'd5, 5'd6, 5'd7, 32'd0, 8'd2);
      applyStimulus(8'd2, 4'hF, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      run = 1'b1;
      waitStart(100, "stale_first");
      @(negedge clk);
      waitStart(100, "stale_second");
      repeat (2) @(negedge clk);
      checkOutput("stale_no_retire_count", 32'(instr_count), 32'd1);
      checkOutput("stale_no_retire_pc", 32'(pc), 32'd1);
      waitHalted(200, "stale");
      checkOutput("stale_pc", 32'(pc), 32'd2);
      checkOutput("stale_count", 32'(instr_count), 32'd2);
      hold_done  = 1'b0;
      pre_cycles = 1;
      endTest("stale");

      // Reset during WAIT_DONE: back to IDLE, later done ignored
      doReset(1'b1);
      clearMem();
      pre_cycles  = 0;
      busy_cycles = 10;
      applyStimulus(8'd0, 4'h0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      applyStimulus(8'd1, 4'h2, 2'd0, 5'd2, 5'd3, 5'd4, 32'd0, 8'd9);
      applyStimulus(8'd2, 4'hF, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      run = 1'b1;
      waitStart(100, "midrst");
      run = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midrst_pre_pc", 32'(pc), 32'd1);
      checkOutput("midrst_pre_count", 32'(instr_count), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cur_imm = 32'd0;
      checkResetState();
      repeat (20) @(negedge clk);
      checkOutput("midrst_late_pc", 32'(pc), 32'd0);
      checkOutput("midrst_late_count", 32'(instr_count), 32'd0);
      checkOutput("midrst_late_halted", 32'(halted), 32'd0);
      busy_cycles = 2;
      pre_cycles  = 1;
      endTest("midrst");

      // Unknown opcode 7 at pc 0
      doReset(1'b1);
      clearMem();
      applyStimulus(8'd0, 4'h7, 2'd0, 5'd1, 5'd1, 5'd1, 32'd0, 8'd0);
      applyStimulus(8'd1, 4'hF, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      run = 1'b1;
      waitHalted(200, "unknown");
`ifdef DECODE_ILLEGAL_TRAP_EN
      checkOutput("unknown_illegal", 32'(illegal), 32'd1);
      checkOutput("unknown_pc", 32'(pc), 32'd0);
      checkOutput("unknown_count", 32'(instr_count), 32'd0);
`else
      checkOutput("unknown_illegal", 32'(illegal), 32'd0);
      checkOutput("unknown_pc", 32'(pc), 32'd1);
      checkOutput("unknown_count", 32'(instr_count), 32'd1);
`endif
      endTest("unknown");

      // ADD returns to 255, NOP there wraps pc to 0 and fetch continues at 0
      doReset(1'b1);
      clearMem();
      applyStimulus(8'd0, 4'h1, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0, 8'd255);
      applyStimulus(8'd255, 4'h0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      run = 1'b1;
      repeat (8) @(negedge clk);
      mem[0] = 32'hF000_0000;
      waitHalted(200, "wrap");
      checkOutput("wrap_pc", 32'(pc), 32'd0);
      checkOutput("wrap_count", 32'(instr_count), 32'd2);
      endTest("wrap");

      // Run pulsed for one cycle: the fetched NOP completes, then the FSM stays idle
      doReset(1'b1);
      clearMem();
      applyStimulus(8'd0, 4'h0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      applyStimulus(8'd1, 4'h0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("runpulse_pc", 32'(pc), 32'd1);
      checkOutput("runpulse_count", 32'(instr_count), 32'd1);
      checkOutput("runpulse_halted", 32'(halted), 32'd0);
      endTest("runpulse");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/instruction_decode_controller.md
INSTRUCTION_DECODE_CONTROLLER -- requirements
Module: instruction_decode_controller

Interface
REQ-001 SHALL take parameter WORD_SIZE, default 32, meaning instruction/operand word width.
REQ-002 SHALL take parameter NUMBER_OF_PC_REGISTERS, default 256; PC_WIDTH = clog2 of it.
REQ-003 SHALL take parameter NUMBER_OF_REGISTERS, default 32; ADDR_WIDTH = clog2 of it, fixed at 5 by the instruction format.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 run  in  1  level; permits fetching new instructions.
REQ-007 imem_addr  out  PC_WIDTH  instruction memory read address.
REQ-008 imem_data  in  WORD_SIZE  instruction memory data, valid one cycle after the address is presented.
REQ-009 add_start, mult_start  out  1  one-cycle start pulses to the add and mult controllers.
REQ-010 exe_pc  out  PC_WIDTH  pc handed to the execution controller.
REQ-011 operation_type  out  2  0=R, 1=I.
REQ-012 source_1_address, source_2_address, destination_address  out  ADDR_WIDTH  rs1/rs2/rd fields.
REQ-013 source_immediate_value  out  WORD_SIZE  immediate operand.
REQ-014 add_busy, add_done, mult_busy, mult_done  in  1  controller status.
REQ-015 add_next_pc, mult_next_pc  in  PC_WIDTH  pc returned by the controllers.
REQ-016 pc  out  PC_WIDTH; halted  out  1; illegal  out  1; instr_count  out  16  retired instructions.

Function
REQ-017 Instruction format SHALL be: [31:28] opcode, [27:26] type, [25:21] rd, [20:16] rs1, [15:11] rs2, [10:0] ignored.
REQ-018 Opcodes SHALL be: 0 NOP, 1 ADD, 2 MULT, F HALT; all others unknown.
REQ-019 FSM states SHALL be IDLE, FETCH, DECODE, FETCH_IMM, LATCH_IMM, ISSUE, WAIT_BUSY, WAIT_DONE, HALT.
REQ-020 IDLE -> FETCH when run=1; otherwise stay in IDLE.
REQ-021 FETCH SHALL drive imem_addr=pc for one cycle; DECODE SHALL latch imem_data.
REQ-022 In DECODE, NOP SHALL set pc=pc+1, increment instr_count and return to IDLE; HALT SHALL go to HALT with halted=1 and pc unchanged.
REQ-023 In DECODE, ADD/MULT with type=I SHALL go to FETCH_IMM, which drives imem_addr=pc+1; LATCH_IMM SHALL capture imem_data into source_immediate_value; exe_pc SHALL be pc+1.
REQ-024 In DECODE, ADD/MULT with type=R SHALL go to ISSUE with exe_pc=pc; source_immediate_value SHALL hold its previous value.
REQ-025 ISSUE SHALL assert exactly one start (add_start or mult_start) for one cycle, with address fields, operation_type and exe_pc stable from ISSUE until WAIT_DONE exits.
REQ-026 WAIT_BUSY SHALL wait for the selected busy=1, so a stale done from a previous instruction is ignored; WAIT_DONE SHALL wait for selected done=1 and busy=0.
REQ-027 On WAIT_DONE exit, pc SHALL load the selected next_pc, instr_count SHALL increment, and the FSM SHALL return to IDLE.
REQ-028 pc arithmetic SHALL wrap modulo 2^PC_WIDTH; for example, pc=255 with NOP gives pc=0.
REQ-029 instr_count SHALL saturate at 16'hFFFF.
REQ-030 Deasserting run SHALL NOT abort an instruction in progress; the current instruction completes and the FSM then stops in IDLE.
REQ-031 HALT SHALL be exited only by rst.

Reset
REQ-032 rst SHALL force state=IDLE, pc=0, instr_count=0, halted=0, illegal=0, add_start=0, mult_start=0, and all address, value and type outputs to 0.
REQ-033 rst in any state, including mid WAIT_DONE, SHALL take effect next edge with no start pulse issued that cycle.

Configuration
REQ-034 Macro DECODE_ILLEGAL_TRAP_EN defined: an unknown opcode SHALL set illegal=1 and halted=1, go to HALT, and leave pc unchanged.
REQ-035 Macro DECODE_ILLEGAL_TRAP_EN undefined: an unknown opcode SHALL behave as NOP (pc+1, counted), and illegal SHALL be tied to 0.

Verification
REQ-036 Program at address 0: MULT R, rd=3, rs1=1, rs2=2, then HALT; mult controller model returns next_pc=1 -> exactly one mult_start with addresses 1/2/3 and type 0, then pc=1, halted=1, instr_count=1.
REQ-037 ADD I at pc=4 with immediate 32'h40400000 at address 5; add controller model returns 6 -> source_immediate_value=32'h40400000, exe_pc=5, pc=6.
REQ-038 Controller model holds done=1 from a prior op before asserting busy -> no retire until busy rises and falls; instr_count increments once.
REQ-039 rst asserted 2 cycles into WAIT_DONE -> next cycle state IDLE, pc=0, no further start pulses; the later controller done is ignored.
REQ-040 Opcode 4'h7 at pc=0 -> with DECODE_ILLEGAL_TRAP_EN: illegal=1, halted=1, pc=0; without it: pc=1, instr_count=1.
REQ-041 pc=255 with NOP, run held at 1 -> pc wraps to 0 and fetch continues from address 0.
